// File: rtl/wt_mem_arbiter.sv
// Merges the write-through I$/D$ request channels into one registered request stream and
// routes memory returns back by source. Optional WT_MEM_ARB_PERF_EN adds conflict/stall counters.

package wt_cache_pkg;
   typedef struct packed {
      logic [31:0] paddr;
      logic        nc;
      logic [1:0]  way;
   } icache_req_t;

   typedef struct packed {
      logic [31:0] paddr;
      logic [63:0] data;
      logic [2:0]  size;
      logic [3:0]  rtype;
      logic        nc;
   } dcache_req_t;
endpackage

module wt_mem_arbiter
   import wt_cache_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        icache_data_req_i,
   output logic        icache_data_ack_o,
   input  icache_req_t icache_data_i,
   input  logic        dcache_data_req_i,
   output logic        dcache_data_ack_o,
   input  dcache_req_t dcache_data_i,
   output logic        mem_req_valid_o,
   input  logic        mem_req_ready_i,
   output logic        mem_req_src_o,
   output icache_req_t mem_req_ic_o,
   output dcache_req_t mem_req_dc_o,
   input  logic        mem_rtrn_vld_i,
   input  logic        mem_rtrn_src_i,
   output logic        icache_rtrn_vld_o,
   output logic        dcache_rtrn_vld_o,
   output logic        idle_o,
   output logic        err_o
`ifdef WT_MEM_ARB_PERF_EN
   ,
   output logic [31:0] conflict_cnt_o,
   output logic [31:0] stall_cnt_o
`endif
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

   logic            valid_q, valid_d;
   logic            src_q, src_d;
   logic            last_q, last_d;  // 1: D$ was granted last
   icache_req_t     ic_q, ic_d;
   dcache_req_t     dc_q, dc_d;
   logic [CntW-1:0] cnt_ic_q, cnt_ic_d;
   logic [CntW-1:0] cnt_dc_q, cnt_dc_d;
   logic            err_q, err_d;
   logic            idle_q, idle_d;

   logic entry_free, elig_ic, elig_dc, gnt_ic, gnt_dc, gnt_any;
   logic ret_ic, ret_dc, uf_ic, uf_dc;

   function automatic logic [CntW-1:0] next_cnt(input logic [CntW-1:0] cnt,
                                                 input logic gnt, input logic ret);
      logic [CntW-1:0] res;
      res = cnt;
      if (gnt && !ret) begin
         res = cnt + 1'b1;
      end else if (ret && !gnt && cnt != '0) begin
         res = cnt - 1'b1;
      end
      return res;
   endfunction

   always_comb begin
      entry_free = ~valid_q | mem_req_ready_i;
      elig_ic    = icache_data_req_i & (cnt_ic_q < CntMax);
      elig_dc    = dcache_data_req_i & (cnt_dc_q < CntMax);
      gnt_ic     = 1'b0;
      gnt_dc     = 1'b0;
      if (entry_free) begin
         if (elig_ic && elig_dc) begin
            gnt_ic = last_q;
            gnt_dc = ~last_q;
         end else begin
            gnt_ic = elig_ic;
            gnt_dc = elig_dc;
         end
      end
      gnt_any = gnt_ic | gnt_dc;

      ret_ic = mem_rtrn_vld_i & ~mem_rtrn_src_i;
      ret_dc = mem_rtrn_vld_i & mem_rtrn_src_i;
      uf_ic  = ret_ic & ~gnt_ic & (cnt_ic_q == '0);
      uf_dc  = ret_dc & ~gnt_dc & (cnt_dc_q == '0);

      valid_d  = gnt_any | (valid_q & ~mem_req_ready_i);
      src_d    = gnt_dc ? 1'b1 : (gnt_ic ? 1'b0 : src_q);
      last_d   = gnt_dc ? 1'b1 : (gnt_ic ? 1'b0 : last_q);
      ic_d     = gnt_ic ? icache_data_i : ic_q;
      dc_d     = gnt_dc ? dcache_data_i : dc_q;
      cnt_ic_d = next_cnt(cnt_ic_q, gnt_ic, ret_ic);
      cnt_dc_d = next_cnt(cnt_dc_q, gnt_dc, ret_dc);
      err_d    = err_q | uf_ic | uf_dc;
      idle_d   = ~valid_d & (cnt_ic_d == '0) & (cnt_dc_d == '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q  <= 1'b0;
         src_q    <= 1'b0;
         last_q   <= 1'b1;
         ic_q     <= '0;
         dc_q     <= '0;
         cnt_ic_q <= '0;
         cnt_dc_q <= '0;
         err_q    <= 1'b0;
         idle_q   <= 1'b1;
      end else begin
         valid_q  <= valid_d;
         src_q    <= src_d;
         last_q   <= last_d;
         ic_q     <= ic_d;
         dc_q     <= dc_d;
         cnt_ic_q <= cnt_ic_d;
         cnt_dc_q <= cnt_dc_d;
         err_q    <= err_d;
         idle_q   <= idle_d;
      end
   end

   assign icache_data_ack_o = gnt_ic;
   assign dcache_data_ack_o = gnt_dc;
   assign mem_req_valid_o   = valid_q;
   assign mem_req_src_o     = src_q;
   assign mem_req_ic_o      = ic_q;
   assign mem_req_dc_o      = dc_q;
   assign icache_rtrn_vld_o = ret_ic;
   assign dcache_rtrn_vld_o = ret_dc;
   assign idle_o            = idle_q;
   assign err_o             = err_q;

`ifdef WT_MEM_ARB_PERF_EN
   logic [31:0] conflict_q, stall_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         conflict_q <= '0;
         stall_q    <= '0;
      end else begin
         if (elig_ic && elig_dc && gnt_any) begin
            conflict_q <= conflict_q + 32'd1;
         end
         if ((icache_data_req_i || dcache_data_req_i) && !gnt_any) begin
            stall_q <= stall_q + 32'd1;
         end
      end
   end

   assign conflict_cnt_o = conflict_q;
   assign stall_cnt_o    = stall_q;
`endif

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Scoreboard bench for wt_mem_arbiter: directed stimulus pushes expected requests, a monitor
// checks each accepted merged request. Second instance exercises MaxOutstanding = 2.

module tb_wt_mem_arbiter;
   import wt_cache_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // Instance A: MaxOutstanding = 4
   logic        ic_req, dc_req, ready, rtrn_vld, rtrn_src;
   icache_req_t ic_pl;
   dcache_req_t dc_pl;
   logic        ic_ack, dc_ack, req_valid, req_src, ic_rv, dc_rv, idle, err;
   icache_req_t req_ic;
   dcache_req_t req_dc;

   // Instance B: MaxOutstanding = 2, I$ only
   logic        b_ic_req, b_rtrn_vld;
   icache_req_t b_ic_pl;
   dcache_req_t b_dc_pl;
   logic        b_ic_ack, b_dc_ack, b_req_valid, b_req_src, b_ic_rv, b_dc_rv, b_idle, b_err;
   icache_req_t b_req_ic;
   dcache_req_t b_req_dc;

`ifdef WT_MEM_ARB_PERF_EN
   logic [31:0] conflict_cnt, stall_cnt, b_conflict_cnt, b_stall_cnt;
`endif

   wt_mem_arbiter #(.MaxOutstanding(4)) u_dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .icache_data_req_i (ic_req),
      .icache_data_ack_o (ic_ack),
      .icache_data_i     (ic_pl),
      .dcache_data_req_i (dc_req),
      .dcache_data_ack_o (dc_ack),
      .dcache_data_i     (dc_pl),
      .mem_req_valid_o   (req_valid),
      .mem_req_ready_i   (ready),
      .mem_req_src_o     (req_src),
      .mem_req_ic_o      (req_ic),
      .mem_req_dc_o      (req_dc),
      .mem_rtrn_vld_i    (rtrn_vld),
      .mem_rtrn_src_i    (rtrn_src),
      .icache_rtrn_vld_o (ic_rv),
      .dcache_rtrn_vld_o (dc_rv),
      .idle_o            (idle),
      .err_o             (err)
`ifdef WT_MEM_ARB_PERF_EN
      ,
      .conflict_cnt_o    (conflict_cnt),
      .stall_cnt_o       (stall_cnt)
`endif
   );

   wt_mem_arbiter #(.MaxOutstanding(2)) u_dut_lim (
      .clk_i             (clk),
      .rst_i             (rst),
      .icache_data_req_i (b_ic_req),
      .icache_data_ack_o (b_ic_ack),
      .icache_data_i     (b_ic_pl),
      .dcache_data_req_i (1'b0),
      .dcache_data_ack_o (b_dc_ack),
      .dcache_data_i     (b_dc_pl),
      .mem_req_valid_o   (b_req_valid),
      .mem_req_ready_i   (1'b1),
      .mem_req_src_o     (b_req_src),
      .mem_req_ic_o      (b_req_ic),
      .mem_req_dc_o      (b_req_dc),
      .mem_rtrn_vld_i    (b_rtrn_vld),
      .mem_rtrn_src_i    (1'b0),
      .icache_rtrn_vld_o (b_ic_rv),
      .dcache_rtrn_vld_o (b_dc_rv),
      .idle_o            (b_idle),
      .err_o             (b_err)
`ifdef WT_MEM_ARB_PERF_EN
      ,
      .conflict_cnt_o    (b_conflict_cnt),
      .stall_cnt_o       (b_stall_cnt)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic        src;
      logic [31:0] addr;
   } exp_t;
   exp_t sb[$];

   // Directed tables: limit test on instance B, grant order for the pre-reset fill on A
   bit lim_ret[11] = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0};
   bit lim_ack[11] = '{1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0};
   bit fill_dc[5]  = '{1, 0, 1, 0, 0};

   task automatic chk1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_req(input logic src, input logic [31:0] addr);
      sb.push_back(exp_t'{src: src, addr: addr});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && req_valid && ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: got request src %0d, want none", req_src);
         end else begin
            e = sb.pop_front();
            chk1("sb_src", req_src, e.src);
            chk32("sb_addr", req_src ? req_dc.paddr : req_ic.paddr, e.addr);
         end
      end
   end

   initial begin
      rst        = 1'b1;
      ic_req     = 1'b0;
      dc_req     = 1'b0;
      ready      = 1'b1;
      rtrn_vld   = 1'b0;
      rtrn_src   = 1'b0;
      ic_pl      = '0;
      dc_pl      = '0;
      b_ic_req   = 1'b0;
      b_rtrn_vld = 1'b0;
      b_ic_pl    = '0;
      b_dc_pl    = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk1("rst_valid", req_valid, 1'b0);
      chk1("rst_idle", idle, 1'b1);
      chk1("rst_err", err, 1'b0);
      chk1("rst_ack_ic", ic_ack, 1'b0);
      chk1("rst_src", req_src, 1'b0);
      chk1("rst_idle_b", b_idle, 1'b1);
`ifdef WT_MEM_ARB_PERF_EN
      chk32("rst_conflict", conflict_cnt, 32'd0);
`endif

      // Single I$ request
      step(); ic_req = 1'b1; ic_pl.paddr = 32'hA1; #1;
      chk1("single_ack_ic", ic_ack, 1'b1);
      chk1("single_ack_dc", dc_ack, 1'b0);
      expect_req(1'b0, 32'hA1);
      step(); ic_req = 1'b0; #1;
      chk1("single_valid", req_valid, 1'b1);
      chk1("single_src", req_src, 1'b0);
      chk1("single_idle", idle, 1'b0);
      step(); rtrn_vld = 1'b1; rtrn_src = 1'b0; #1;
      chk1("single_rv_ic", ic_rv, 1'b1);
      chk1("single_rv_dc", dc_rv, 1'b0);
      chk1("single_idle_out", idle, 1'b0);
      step(); rtrn_vld = 1'b0; #1;
      chk1("single_idle_back", idle, 1'b1);
      chk1("single_err", err, 1'b0);

      // Fresh pointer so I$ wins the first conflict
      step(); rst = 1'b1;
      step(); rst = 1'b0;

      // Round robin, both held, returns one cycle after issue
      for (int k = 0; k < 10; k++) begin
         step();
         ic_req      = (k < 8);
         dc_req      = (k < 8);
         ic_pl.paddr = 32'h100 + 32'(k);
         dc_pl.paddr = 32'h200 + 32'(k);
         rtrn_vld    = (k >= 2);
         rtrn_src    = k[0];
         #1;
         if (k < 8) begin
            chk1("rr_ack_ic", ic_ack, k[0] == 1'b0);
            chk1("rr_ack_dc", dc_ack, k[0] == 1'b1);
            if (k[0]) expect_req(1'b1, 32'h200 + 32'(k));
            else      expect_req(1'b0, 32'h100 + 32'(k));
         end
`ifdef WT_MEM_ARB_PERF_EN
         if (k == 8) chk32("rr_conflict_cnt", conflict_cnt, 32'd8);
`endif
      end
      step(); rtrn_vld = 1'b0; #1;
      chk1("rr_idle", idle, 1'b1);
      chk1("rr_err", err, 1'b0);

      // Backpressure after a D$ grant
      step(); dc_req = 1'b1; dc_pl.paddr = 32'hB0; #1;
      chk1("bp_ack_dc", dc_ack, 1'b1);
      expect_req(1'b1, 32'hB0);
      for (int k = 0; k < 5; k++) begin
         step();
         dc_req      = 1'b0;
         ready       = 1'b0;
         ic_req      = 1'b1;
         ic_pl.paddr = 32'hC0;
         dc_pl.paddr = 32'hDEAD + 32'(k);
         #1;
         chk1("bp_no_ack", ic_ack, 1'b0);
         chk1("bp_valid", req_valid, 1'b1);
         chk1("bp_src", req_src, 1'b1);
         chk32("bp_payload", req_dc.paddr, 32'hB0);
      end
      step(); ready = 1'b1; #1;
      chk1("bp_ack_ic_on_ready", ic_ack, 1'b1);
      chk1("bp_ack_dc_on_ready", dc_ack, 1'b0);
      expect_req(1'b0, 32'hC0);
      step(); ic_req = 1'b0; #1;
      chk1("bp_next_valid", req_valid, 1'b1);
      chk1("bp_next_src", req_src, 1'b0);
      step(); rtrn_vld = 1'b1; rtrn_src = 1'b1; #1;
      step(); rtrn_src = 1'b0; #1;
      step(); rtrn_vld = 1'b0; #1;
      chk1("bp_idle", idle, 1'b1);
      chk1("bp_err", err, 1'b0);
`ifdef WT_MEM_ARB_PERF_EN
      chk32("bp_stall_cnt", stall_cnt, 32'd5);
      chk32("bp_conflict_cnt", conflict_cnt, 32'd8);
`endif

      // Outstanding limit of 2 on instance B
      for (int k = 0; k < 11; k++) begin
         step();
         b_ic_req      = 1'b1;
         b_ic_pl.paddr = 32'(k);
         b_rtrn_vld    = lim_ret[k];
         #1;
         chk1("lim_ack", b_ic_ack, lim_ack[k]);
      end
      step(); b_ic_req = 1'b0; b_rtrn_vld = 1'b1; #1;
      chk1("lim_rv", b_ic_rv, 1'b1);
      step(); #1;
      step(); b_rtrn_vld = 1'b0; #1;
      chk1("lim_idle", b_idle, 1'b1);
      chk1("lim_err", b_err, 1'b0);

      // Underflow on D$
      step(); rtrn_vld = 1'b1; rtrn_src = 1'b1; #1;
      chk1("uf_rv_dc", dc_rv, 1'b1);
      chk1("uf_rv_ic", ic_rv, 1'b0);
      chk1("uf_err_same_cycle", err, 1'b0);
      step(); rtrn_vld = 1'b0; #1;
      chk1("uf_err_set", err, 1'b1);
      chk1("uf_idle", idle, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step(); #1;
         chk1("uf_err_sticky", err, 1'b1);
      end

      // Fill to I$ = 3, D$ = 2 outstanding with a stuck entry, then reset
      for (int k = 0; k < 5; k++) begin
         step();
         ic_req      = 1'b1;
         dc_req      = (k < 4);
         ic_pl.paddr = 32'h300 + 32'(k);
         dc_pl.paddr = 32'h400 + 32'(k);
         #1;
         chk1("fill_ack_dc", dc_ack, fill_dc[k]);
         chk1("fill_ack_ic", ic_ack, !fill_dc[k]);
         if (k < 4) begin
            if (fill_dc[k]) expect_req(1'b1, 32'h400 + 32'(k));
            else            expect_req(1'b0, 32'h300 + 32'(k));
         end
      end
      step(); ic_req = 1'b0; dc_req = 1'b0; ready = 1'b0; #1;
      chk1("fill_valid", req_valid, 1'b1);
      chk1("fill_idle", idle, 1'b0);
      step(); rst = 1'b1; #1;
      step(); rst = 1'b0; ready = 1'b1; #1;
      chk1("mrst_valid", req_valid, 1'b0);
      chk1("mrst_idle", idle, 1'b1);
      chk1("mrst_ack_ic", ic_ack, 1'b0);
      chk1("mrst_ack_dc", dc_ack, 1'b0);
      chk1("mrst_err", err, 1'b0);
      step(); ic_req = 1'b1; dc_req = 1'b1; ic_pl.paddr = 32'h500; #1;
      chk1("mrst_conflict_ic", ic_ack, 1'b1);
      chk1("mrst_conflict_dc", dc_ack, 1'b0);
      expect_req(1'b0, 32'h500);
      step(); ic_req = 1'b0; dc_req = 1'b0; #1;
      step(); rtrn_vld = 1'b1; rtrn_src = 1'b0; #1;
      chk1("mrst_ret_ok", err, 1'b0);
      step(); rtrn_src = 1'b1; #1;
      chk1("mrst_stale_rv", dc_rv, 1'b1);
      step(); rtrn_vld = 1'b0; #1;
      chk1("mrst_stale_err", err, 1'b1);

      chk32("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
